// File: rtl/stage3_execute.sv
// rtl/stage3_execute.sv - execute stage: ALU, branch resolve, shift-add MUL, stage-4 output registers
//
// Purpose:
//    Computes the ALU result for the instruction delivered by stage 2.
//    Resolves the branch condition and registers everything into stage 4.
//    MUL runs on a 32-iteration shift-add engine. It holds stage 2 via
//    stall_o while it is busy.
//
// Ports:
//    clk_i, rst_i                        clock, asynchronous active-high reset
//    a_i, b_i                            operands (b_i[4:0] is the shift amount)
//    cond_i                              value tested by conditional branches
//    aluop_i                             0 ADD .. 11 MUL, 12-15 reserved (result 0)
//    branch_i                            00 none, 01 always, 10 cond==0, 11 cond!=0
//    control_load_i, control_store_i,
//    do_wb_i, wb_reg_i                   control fields passed through to stage 4
//    stall_i                             downstream stall: hold every register
//    flush_i                             squash this stage: bubble, abort MUL
//    stall_o                             combinational upstream hold request
//    alu_o, control_*_o, do_wb_o,
//    wb_reg_o                            registered stage-4 inputs

module stage3_execute (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] cond_i,
   input  logic [3:0]  aluop_i,
   input  logic [1:0]  branch_i,
   input  logic        control_load_i,
   input  logic        control_store_i,
   input  logic        do_wb_i,
   input  logic [3:0]  wb_reg_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [31:0] alu_o,
   output logic        control_load_o,
   output logic        control_store_o,
   output logic        control_take_branch_o,
   output logic        do_wb_o,
   output logic [3:0]  wb_reg_o
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_LSL  = 4'd5;
   localparam logic [3:0] OP_LSR  = 4'd6;
   localparam logic [3:0] OP_ASR  = 4'd7;
   localparam logic [3:0] OP_MOVB = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;

   // Control fields of the MUL, captured at acceptance
   logic        m_load_q, m_load_d;
   logic        m_store_q, m_store_d;
   logic        m_take_q, m_take_d;
   logic        m_wb_q, m_wb_d;
   logic [3:0]  m_reg_q, m_reg_d;

   logic [31:0] alu_d;
   logic        load_d, store_d, take_d, wb_d;
   logic [3:0]  reg_d;

   logic [31:0] alu_res;
   logic        take_res;
   logic [4:0]  shamt;
   logic [31:0] acc_sum;
   logic        is_mul;

   assign shamt  = b_i[4:0];
   assign is_mul = (aluop_i == OP_MUL);

   always_comb begin
      alu_res = 32'd0;
      case (aluop_i)
         OP_ADD:  alu_res = a_i + b_i;
         OP_SUB:  alu_res = a_i - b_i;
         OP_AND:  alu_res = a_i & b_i;
         OP_OR:   alu_res = a_i | b_i;
         OP_XOR:  alu_res = a_i ^ b_i;
         OP_LSL:  alu_res = a_i << shamt;
         OP_LSR:  alu_res = a_i >> shamt;
         OP_ASR:  alu_res = $unsigned($signed(a_i) >>> shamt);
         OP_MOVB: alu_res = b_i;
         OP_SLT:  alu_res = {31'd0, ($signed(a_i) < $signed(b_i))};
         OP_SLTU: alu_res = {31'd0, (a_i < b_i)};
         default: alu_res = 32'd0;
      endcase
   end

   always_comb begin
      take_res = 1'b0;
      case (branch_i)
         2'b01:   take_res = 1'b1;
         2'b10:   take_res = (cond_i == 32'd0);
         2'b11:   take_res = (cond_i != 32'd0);
         default: take_res = 1'b0;
      endcase
   end

   // One shift-add step; the final step's sum is the product written out
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

   // Flush does not block the BUSY term: the squash takes effect at the edge
   assign stall_o = stall_i
                  | ((state_q == ST_IDLE) & is_mul & ~flush_i)
                  | ((state_q == ST_BUSY) & (count_q != 5'd31));

   always_comb begin
      // Default: hold everything (covers stall_i)
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      m_load_d  = m_load_q;
      m_store_d = m_store_q;
      m_take_d  = m_take_q;
      m_wb_d    = m_wb_q;
      m_reg_d   = m_reg_q;
      alu_d     = alu_o;
      load_d    = control_load_o;
      store_d   = control_store_o;
      take_d    = control_take_branch_o;
      wb_d      = do_wb_o;
      reg_d     = wb_reg_o;

      if (flush_i) begin
         state_d = ST_IDLE;
         count_d = 5'd0;
         acc_d   = 32'd0;
         alu_d   = 32'd0;
         load_d  = 1'b0;
         store_d = 1'b0;
         take_d  = 1'b0;
         wb_d    = 1'b0;
         reg_d   = 4'd0;
      end else if (!stall_i) begin
         // Bubble unless a result is written below
         alu_d   = 32'd0;
         load_d  = 1'b0;
         store_d = 1'b0;
         take_d  = 1'b0;
         wb_d    = 1'b0;
         reg_d   = 4'd0;
         case (state_q)
            ST_IDLE: begin
               if (is_mul) begin
                  state_d   = ST_BUSY;
                  count_d   = 5'd0;
                  acc_d     = 32'd0;
                  mcand_d   = a_i;
                  mplier_d  = b_i;
                  m_load_d  = control_load_i;
                  m_store_d = control_store_i;
                  m_take_d  = take_res;
                  m_wb_d    = do_wb_i;
                  m_reg_d   = wb_reg_i;
               end else begin
                  alu_d   = alu_res;
                  load_d  = control_load_i;
                  store_d = control_store_i;
                  take_d  = take_res;
                  wb_d    = do_wb_i;
                  reg_d   = wb_reg_i;
               end
            end
            ST_BUSY: begin
               acc_d    = acc_sum;
               mcand_d  = {mcand_q[30:0], 1'b0};
               mplier_d = {1'b0, mplier_q[31:1]};
               count_d  = count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_d = ST_IDLE;
                  count_d = 5'd0;
                  alu_d   = acc_sum;
                  load_d  = m_load_q;
                  store_d = m_store_q;
                  take_d  = m_take_q;
                  wb_d    = m_wb_q;
                  reg_d   = m_reg_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q               <= ST_IDLE;
         count_q               <= 5'd0;
         acc_q                 <= 32'd0;
         mcand_q               <= 32'd0;
         mplier_q              <= 32'd0;
         m_load_q              <= 1'b0;
         m_store_q             <= 1'b0;
         m_take_q              <= 1'b0;
         m_wb_q                <= 1'b0;
         m_reg_q               <= 4'd0;
         alu_o                 <= 32'd0;
         control_load_o        <= 1'b0;
         control_store_o       <= 1'b0;
         control_take_branch_o <= 1'b0;
         do_wb_o               <= 1'b0;
         wb_reg_o              <= 4'd0;
      end else begin
         state_q               <= state_d;
         count_q               <= count_d;
         acc_q                 <= acc_d;
         mcand_q               <= mcand_d;
         mplier_q              <= mplier_d;
         m_load_q              <= m_load_d;
         m_store_q             <= m_store_d;
         m_take_q              <= m_take_d;
         m_wb_q                <= m_wb_d;
         m_reg_q               <= m_reg_d;
         alu_o                 <= alu_d;
         control_load_o        <= load_d;
         control_store_o       <= store_d;
         control_take_branch_o <= take_d;
         do_wb_o               <= wb_d;
         wb_reg_o              <= reg_d;
      end
   end

endmodule

// File: doc/stage3_execute.md
# stage3_execute

Execute stage of the five-stage pipeline: takes decoded operands and control from stage 2, computes the ALU result, resolves branch conditions and registers everything into stage 4 (memory). Single-cycle ops complete in one clock; MUL runs on a 32-iteration shift-add multiplier and stalls upstream while busy. The stage also honours a downstream stall and a branch flush.

## Interface
Parameters: none.

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- a_i  in  32  operand A (register value or PC)
- b_i  in  32  operand B (register value or immediate)
- cond_i  in  32  register value tested by conditional branches
- aluop_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR, 7 ASR, 8 MOVB, 9 SLT, 10 SLTU, 11 MUL, 12-15 reserved
- branch_i  in  2  00 none, 01 always, 10 if cond_i==0, 11 if cond_i!=0
- control_load_i, control_store_i  in  1  load/store flags, passed through
- do_wb_i  in  1  writeback enable, passed through
- wb_reg_i  in  4  destination register, passed through
- stall_i  in  1  stall from stage 4
- flush_i  in  1  squash the instruction currently in this stage
- stall_o  out  1  hold stage-2 outputs stable this cycle
- alu_o  out  32  registered result; branch target for branches
- control_load_o, control_store_o, control_take_branch_o, do_wb_o  out  1  registered
- wb_reg_o  out  4  registered

## Operation
- Arithmetic is 32-bit, wrapping. Shifts use b_i[4:0]. ASR sign-fills. SLT/SLTU return 1 or 0, signed/unsigned. MOVB returns b_i. Reserved ops return 0, and other fields pass through.
- control_take_branch_o = branch_i decode on cond_i. The target is alu_o (stage 2 issues ADD of PC and offset).
- "Bubble" means all output flags = 0, wb_reg_o = 0, and alu_o = 0.
- FSM states:
  - IDLE: a non-MUL op is registered to the outputs at the edge. For MUL (flush_i=0, stall_i=0): latch a_i, b_i and the control fields, clear the accumulator, set count=0, go to BUSY, and register a bubble.
  - BUSY: each edge adds the shifted multiplicand if the multiplier LSB is 1, shifts, and does count+1. Edges with count<31 register a bubble. The edge at count==31 registers the low 32 bits of the product with the latched control fields, then returns to IDLE.
- Multiplier inputs are ignored in BUSY; upstream holds them by stall_o.
- stall_o = stall_i | (IDLE & aluop_i==MUL & !flush_i) | (BUSY & count<31). It is combinational.
- Priority: rst_i > flush_i > stall_i > normal.
  - flush_i: register a bubble and force IDLE (aborts MUL), with no stall contribution.
  - stall_i (no flush): all output registers, FSM state, count and accumulator hold.
- Reset: all outputs 0, IDLE, count 0, accumulator 0. Reset mid-MUL abandons it with no output.

## Timing
- Single-cycle op presented in cycle N: outputs valid after the edge ending N. Latency 1.
- MUL presented in IDLE in cycle N: stall_o high in cycles N..N+31 and low in N+32. The result is on the outputs after the edge ending N+32. Bubbles are on the outputs after the edges ending N..N+31. Upstream advances at the edge ending N+32.
- stall_i during BUSY extends the MUL by one cycle per stalled cycle, with no lost iterations.
- flush_i with stall_i in the same cycle: flush wins.
- MUL followed by MUL: the second is accepted in cycle N+33 from IDLE.

## Test plan
- ADD 0xFFFFFFFF+2, SUB 0-1, ASR 0x80000000 by 4, SLT -1<1, SLTU -1<1 -> alu_o 1, 0xFFFFFFFF, 0xF8000000, 1, 0, each one cycle later.
- Branch: branch_i=10, cond_i=0, ADD 0x100+0x20 -> take_branch_o=1, alu_o=0x120. Repeat with cond_i=5 -> take_branch_o=0.
- MUL 0x12345678 × 0x9, do_wb_i=1, wb_reg_i=3 -> stall_o high 32 cycles, do_wb_o=0 during that time, then alu_o=0xA3D70A38, do_wb_o=1, wb_reg_o=3.
- MUL with stall_i pulsed 3 cycles mid-operation -> result at N+35, value unchanged. Outputs hold while stall_i is high.
- flush_i at count 10 of a MUL -> bubble, stall_o low next cycle, the next ADD completes normally.
- rst_i asserted asynchronously mid-MUL -> all outputs 0 immediately, stall_o low, and the following op executes from IDLE.
